// File: rtl/updown_step_ctrl.sv
// -----------------------------------------------------------------------------
// updown_step_ctrl
//
// Modulo up/down counter driven by two debounced push buttons. Each press pulse
// steps the count once. When built with UPDOWN_AUTO_REPEAT_EN defined, holding
// a button for HOLD_CYCLES starts auto-repeat: one further step every
// REPEAT_CYCLES while the button stays held. Without the macro, each accepted
// press steps exactly once and the levels are ignored.
//
// Configuration macro: UPDOWN_AUTO_REPEAT_EN (undefined = press-only stepping)
//
// Parameters
//   WIDTH         count register width
//   MAX_COUNT     highest count value (1 .. 2^WIDTH-1); count wraps 0 <-> MAX
//   HOLD_CYCLES   cycles a button is held before auto-repeat starts
//   REPEAT_CYCLES cycles between auto-repeat steps
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   up_press   in   one-cycle press pulse, up button
//   up_level   in   debounced held level, up button
//   dn_press   in   one-cycle press pulse, down button
//   dn_level   in   debounced held level, down button
//   count      out  registered counter value
//   wrap       out  one-cycle pulse registered with a wrap-around step
// -----------------------------------------------------------------------------
module updown_step_ctrl #(
    parameter int WIDTH         = 4,
    parameter int MAX_COUNT     = 9,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_press,
    input  logic             up_level,
    input  logic             dn_press,
    input  logic             dn_level,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_COUNT);

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             wrap;
    } step_t;

    // Next count and wrap flag for one step in the given direction.
    function automatic step_t f_step(input logic [WIDTH-1:0] cur, input logic up);
        step_t s;
        s.wrap = 1'b0;
        if (up) begin
            if (cur == LP_MAX) begin
                s.count = '0;
                s.wrap  = 1'b1;
            end else begin
                s.count = cur + WIDTH'(1);
            end
        end else begin
            if (cur == '0) begin
                s.count = LP_MAX;
                s.wrap  = 1'b1;
            end else begin
                s.count = cur - WIDTH'(1);
            end
        end
        return s;
    endfunction

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    step_t            w_up_step;
    step_t            w_dn_step;
    logic             w_up_only;
    logic             w_dn_only;

    assign w_up_step = f_step(r_count, 1'b1);
    assign w_dn_step = f_step(r_count, 1'b0);
    // Simultaneous presses cancel each other.
    assign w_up_only = up_press & ~dn_press;
    assign w_dn_only = dn_press & ~up_press;

    assign count = r_count;
    assign wrap  = r_wrap;

`ifdef UPDOWN_AUTO_REPEAT_EN

    localparam int LP_MAX_T = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW       = $clog2(LP_MAX_T + 1);
    localparam logic [TW-1:0] LP_HOLD_END = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LP_RPT_END  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD_UP = 3'd1,
        RPT_UP  = 3'd2,
        HOLD_DN = 3'd3,
        RPT_DN  = 3'd4
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          w_dir_up;
    logic          w_level;
    step_t         w_dir_step;

    // Only the button that started the sequence matters; the other is ignored.
    assign w_dir_up   = (r_state == HOLD_UP) || (r_state == RPT_UP);
    assign w_level    = w_dir_up ? up_level : dn_level;
    assign w_dir_step = w_dir_up ? w_up_step : w_dn_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            // NOTE: non-blocking default; a later assignment in this block
            // overrides it, so wrap is a pulse only on the wrapping step.
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_up_only) begin
                        {r_count, r_wrap} <= w_up_step;
                        r_state           <= HOLD_UP;
                    end else if (w_dn_only) begin
                        {r_count, r_wrap} <= w_dn_step;
                        r_state           <= HOLD_DN;
                    end
                end
                HOLD_UP, HOLD_DN: begin
                    if (!w_level) begin
                        r_timer <= '0;
                        r_state <= IDLE;
                    end else if (r_timer == LP_HOLD_END) begin
                        {r_count, r_wrap} <= w_dir_step;
                        r_timer           <= '0;
                        r_state           <= w_dir_up ? RPT_UP : RPT_DN;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RPT_UP, RPT_DN: begin
                    if (!w_level) begin
                        r_timer <= '0;
                        r_state <= IDLE;
                    end else if (r_timer == LP_RPT_END) begin
                        {r_count, r_wrap} <= w_dir_step;
                        r_timer           <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`else

    // Levels and timing parameters only matter with auto-repeat enabled.
    logic w_unused_cfg;
    assign w_unused_cfg = up_level ^ dn_level ^ (HOLD_CYCLES > 0) ^ (REPEAT_CYCLES > 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            // NOTE: non-blocking default; a later assignment in this block
            // overrides it, so wrap is a pulse only on the wrapping step.
            r_wrap <= 1'b0;
            if (w_up_only) begin
                {r_count, r_wrap} <= w_up_step;
            end else if (w_dn_only) begin
                {r_count, r_wrap} <= w_dn_step;
            end
        end
    end

`endif

endmodule

// File: tb/tb_updown_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_step_ctrl
//
// Directed sequences plus a randomized run, each cycle compared against a
// behavioural model that counts cycles since the accepted press: a held press
// steps at the press, again HOLD cycles later, then every REPEAT cycles.
// The model follows UPDOWN_AUTO_REPEAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_updown_step_ctrl;

    localparam int WIDTH  = 4;
    localparam int MAXC   = 9;
    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    logic             clk;
    logic             rst_n;
    logic             up_press;
    logic             up_level;
    logic             dn_press;
    logic             dn_level;
    logic [WIDTH-1:0] count;
    logic             wrap;

    updown_step_ctrl #(
        .WIDTH        (WIDTH),
        .MAX_COUNT    (MAXC),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_press(up_press),
        .up_level(up_level),
        .dn_press(dn_press),
        .dn_level(dn_level),
        .count   (count),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_count  = 0;
    bit m_wrap   = 0;
    bit m_active = 0;
    bit m_dir_up = 0;
    int m_n      = 0;

`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic m_reset();
        m_count  = 0;
        m_wrap   = 0;
        m_active = 0;
        m_n      = 0;
    endtask

    task automatic m_step(input bit up);
        if (up) begin
            m_wrap  = (m_count == MAXC);
            m_count = m_wrap ? 0 : m_count + 1;
        end else begin
            m_wrap  = (m_count == 0);
            m_count = m_wrap ? MAXC : m_count - 1;
        end
    endtask

    // One rising edge of the model, using the inputs sampled at that edge.
    task automatic m_edge(input bit up_p, input bit up_l, input bit dn_p, input bit dn_l);
        bit lvl;
        m_wrap = 0;
        if (!m_active) begin
            if (up_p != dn_p) begin
                m_step(up_p);
                m_dir_up = up_p;
                m_active = AUTO;
                m_n      = 0;
            end
        end else begin
            lvl = m_dir_up ? up_l : dn_l;
            if (!lvl) begin
                m_active = 0;
            end else begin
                m_n++;
                if (m_n == HOLD || (m_n > HOLD && (m_n - HOLD) % REPEAT == 0))
                    m_step(m_dir_up);
            end
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (count === WIDTH'(m_count)) else begin
            miscompares++;
            $error("FAIL %s: count observed=%0d expected=%0d", tag, count, m_count);
        end
        vectors++;
        assert (wrap === m_wrap) else begin
            miscompares++;
            $error("FAIL %s: wrap observed=%0b expected=%0b", tag, wrap, m_wrap);
        end
    endtask

    task automatic check_const(input string tag, input int expected);
        vectors++;
        assert (count === WIDTH'(expected)) else begin
            miscompares++;
            $error("FAIL %s: count observed=%0d expected=%0d", tag, count, expected);
        end
    endtask

    // Apply inputs for one cycle (called at posedge+1), clock, then compare.
    task automatic cycle(input bit up_p, input bit up_l, input bit dn_p, input bit dn_l,
                         input string tag);
        up_press = up_p;
        up_level = up_l;
        dn_press = dn_p;
        dn_level = dn_l;
        @(posedge clk);
        m_edge(up_p, up_l, dn_p, dn_l);
        #1;
        check(tag);
    endtask

    initial begin
        bit ul, dl;
        up_press = 0; up_level = 0; dn_press = 0; dn_level = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        m_reset();
        check("reset_async");
        @(posedge clk);
        #1;
        check("reset_held");
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, "idle_after_reset");

        // Three single up pulses with the level released.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, "single_up");
            cycle(0, 0, 0, 0, "single_up_gap");
        end
        check_const("single_up_total", 3);

        // Climb to MAX, then wrap up and back down.
        while (m_count != MAXC) begin
            cycle(1, 0, 0, 0, "climb");
            cycle(0, 0, 0, 0, "climb_gap");
        end
        check_const("at_max", MAXC);
        cycle(1, 0, 0, 0, "wrap_up");
        check_const("wrap_up_value", 0);
        cycle(0, 0, 0, 0, "wrap_up_clear");
        cycle(0, 0, 1, 0, "wrap_dn");
        check_const("wrap_dn_value", MAXC);
        cycle(0, 0, 0, 0, "wrap_dn_clear");
        cycle(1, 0, 0, 0, "to_zero");
        cycle(0, 0, 0, 0, "to_zero_gap");

        // Press and hold up for 20 cycles from zero.
        cycle(1, 1, 0, 0, "hold_press");
        for (int i = 1; i < 20; i++) cycle(0, 1, 0, 0, "hold_run");
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, "hold_released");
        check_const("hold_total", AUTO ? 4 : 1);

        // Reach 5, then press both buttons together.
        while (m_count != 5) begin
            cycle(1, 0, 0, 0, "to_five");
            cycle(0, 0, 0, 0, "to_five_gap");
        end
        cycle(1, 1, 1, 1, "dual_press");
        check_const("dual_press_value", 5);
        cycle(0, 0, 0, 0, "dual_press_gap");
        cycle(1, 0, 0, 0, "after_dual");
        cycle(0, 0, 0, 0, "after_dual_gap");

        // Async reset in the middle of auto-repeat with the button still held.
        cycle(1, 1, 0, 0, "rst_hold_press");
        for (int i = 0; i < 13; i++) cycle(0, 1, 0, 0, "rst_hold_run");
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_mid_repeat");
        check_const("rst_mid_repeat_zero", 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) cycle(0, 1, 0, 0, "rst_still_held");
        check_const("rst_no_step", 0);
        cycle(1, 1, 0, 0, "rst_new_press");
        check_const("rst_new_press_value", 1);
        cycle(0, 0, 0, 0, "rst_release");

        // Randomized run: long-lived levels, sparse presses in both directions.
        ul = 0;
        dl = 0;
        for (int i = 0; i < 400; i++) begin
            bit up_p, dn_p;
            if ($urandom_range(0, 9) == 0) ul = ~ul;
            if ($urandom_range(0, 9) == 0) dl = ~dl;
            up_p = ($urandom_range(0, 5) == 0);
            dn_p = ($urandom_range(0, 5) == 0);
            cycle(up_p, ul, dn_p, dl, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
